// File: rtl/crtc_pkg.sv
// Shared definitions for the programmable text CRTC: register indices, field
// widths, reset defaults and the register-file readback helper.
package crtc_pkg;

    localparam int unsigned CRTC_IDX_W  = 4;
    localparam int unsigned CRTC_DATA_W = 8;
    localparam int unsigned CRTC_SCAN_W = 4;

    localparam logic [CRTC_IDX_W-1:0] CRTC_REG_START_HI  = 4'd0;
    localparam logic [CRTC_IDX_W-1:0] CRTC_REG_START_LO  = 4'd1;
    localparam logic [CRTC_IDX_W-1:0] CRTC_REG_CUR_HI    = 4'd2;
    localparam logic [CRTC_IDX_W-1:0] CRTC_REG_CUR_LO    = 4'd3;
    localparam logic [CRTC_IDX_W-1:0] CRTC_REG_MAX_SCAN  = 4'd4;
    localparam logic [CRTC_IDX_W-1:0] CRTC_REG_CUR_START = 4'd5;
    localparam logic [CRTC_IDX_W-1:0] CRTC_REG_CUR_END   = 4'd6;
    localparam logic [CRTC_IDX_W-1:0] CRTC_REG_STRIDE    = 4'd7;

    localparam logic [CRTC_SCAN_W-1:0] CRTC_RST_MAX_SCAN  = 4'd7;
    localparam logic [CRTC_SCAN_W-1:0] CRTC_RST_CUR_START = 4'd6;
    localparam logic [CRTC_SCAN_W-1:0] CRTC_RST_CUR_END   = 4'd7;
    localparam logic [CRTC_DATA_W-1:0] CRTC_RST_STRIDE    = 8'd80;

    typedef struct packed {
        logic [CRTC_DATA_W-1:0] startHi;
        logic [CRTC_DATA_W-1:0] startLo;
        logic [CRTC_DATA_W-1:0] curHi;
        logic [CRTC_DATA_W-1:0] curLo;
        logic [CRTC_SCAN_W-1:0] maxScan;
        logic [CRTC_SCAN_W-1:0] curStart;
        logic [CRTC_SCAN_W-1:0] curEnd;
        logic [CRTC_DATA_W-1:0] stride;
    } crtc_regs_t;

    localparam crtc_regs_t CRTC_REGS_RST = '{
        startHi:  8'd0,
        startLo:  8'd0,
        curHi:    8'd0,
        curLo:    8'd0,
        maxScan:  CRTC_RST_MAX_SCAN,
        curStart: CRTC_RST_CUR_START,
        curEnd:   CRTC_RST_CUR_END,
        stride:   CRTC_RST_STRIDE
    };

    // Unimplemented indices and unused high bits read as zero.
    function automatic logic [CRTC_DATA_W-1:0] crtcRegRead(input crtc_regs_t r,
                                                          input logic [CRTC_IDX_W-1:0] idx);
        logic [CRTC_DATA_W-1:0] d;
        d = '0;
        case (idx)
            CRTC_REG_START_HI:  d = r.startHi;
            CRTC_REG_START_LO:  d = r.startLo;
            CRTC_REG_CUR_HI:    d = r.curHi;
            CRTC_REG_CUR_LO:    d = r.curLo;
            CRTC_REG_MAX_SCAN:  d = CRTC_DATA_W'(r.maxScan);
            CRTC_REG_CUR_START: d = CRTC_DATA_W'(r.curStart);
            CRTC_REG_CUR_END:   d = CRTC_DATA_W'(r.curEnd);
            CRTC_REG_STRIDE:    d = r.stride;
            default:            d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/crtc_regfile.sv
// Indexed CRTC register file: live registers, frame-boundary shadow copy with
// same-cycle write forwarding, and registered readback.
module crtc_regfile
    import crtc_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
) (
    input  logic                   iClk25,
    input  logic                   iRstN,
    input  logic [CRTC_IDX_W-1:0]  iRegIdx,
    input  logic                   iRegWr,
    input  logic [CRTC_DATA_W-1:0] iRegData,
    input  logic                   iFrameEnd,
    output logic [CRTC_DATA_W-1:0] oRegData,
    output logic [ADDR_W-1:0]      oCur,
    output logic [CRTC_SCAN_W-1:0] oMaxScan,
    output logic [CRTC_SCAN_W-1:0] oCurStart,
    output logic [CRTC_SCAN_W-1:0] oCurEnd,
    output logic [CRTC_DATA_W-1:0] oStride,
    output logic [ADDR_W-1:0]      oStartLoad_c
);

    localparam int unsigned HI_W = ADDR_W - CRTC_DATA_W;

    crtc_regs_t live;
    crtc_regs_t liveNext;

    // Post-write view of the live registers; the shadow loads from this so a
    // write on the boundary cycle lands in the new frame.
    always_comb begin
        liveNext = live;
        if (iRegWr) begin
            case (iRegIdx)
                CRTC_REG_START_HI:  liveNext.startHi  = CRTC_DATA_W'(iRegData[HI_W-1:0]);
                CRTC_REG_START_LO:  liveNext.startLo  = iRegData;
                CRTC_REG_CUR_HI:    liveNext.curHi    = CRTC_DATA_W'(iRegData[HI_W-1:0]);
                CRTC_REG_CUR_LO:    liveNext.curLo    = iRegData;
                CRTC_REG_MAX_SCAN:  liveNext.maxScan  = iRegData[CRTC_SCAN_W-1:0];
                CRTC_REG_CUR_START: liveNext.curStart = iRegData[CRTC_SCAN_W-1:0];
                CRTC_REG_CUR_END:   liveNext.curEnd   = iRegData[CRTC_SCAN_W-1:0];
                CRTC_REG_STRIDE:    liveNext.stride   = iRegData;
                default: ;
            endcase
        end
    end

    // Start address is consumed directly by the row-address counter at frame wrap.
    assign oStartLoad_c = {liveNext.startHi[HI_W-1:0], liveNext.startLo};

    always_ff @(posedge iClk25 or negedge iRstN) begin
        if (!iRstN) begin
            live      <= CRTC_REGS_RST;
            oRegData  <= '0;
            oCur      <= '0;
            oMaxScan  <= CRTC_RST_MAX_SCAN;
            oCurStart <= CRTC_RST_CUR_START;
            oCurEnd   <= CRTC_RST_CUR_END;
            oStride   <= CRTC_RST_STRIDE;
        end else begin
            live     <= liveNext;
            oRegData <= crtcRegRead(live, iRegIdx);
            if (iFrameEnd) begin
                oCur      <= {liveNext.curHi[HI_W-1:0], liveNext.curLo};
                oMaxScan  <= liveNext.maxScan;
                oCurStart <= liveNext.curStart;
                oCurEnd   <= liveNext.curEnd;
                oStride   <= liveNext.stride;
            end
        end
    end

endmodule

// File: rtl/video_crtc_prog.sv
// Programmable text-mode CRTC: raster counters, character/row/dot addressing,
// sync/blank and hardware cursor. Define CRTC_CURSOR_BLINK_EN for a 16/16-frame cursor blink.
module video_crtc_prog
    import crtc_pkg::*;
#(
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_TOT   = 800,
    parameter int unsigned V_VIS   = 400,
    parameter int unsigned V_FP    = 12,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_TOT   = 449,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b1,
    parameter int unsigned ROW_REP = 2,
    parameter int unsigned DOT_W   = 4,
    parameter int unsigned ADDR_W  = 14
) (
    input  logic              iClk25,
    input  logic              iRstN,
    input  logic [3:0]        iRegIdx,
    input  logic              iRegWr,
    input  logic [7:0]        iRegData,
    output logic [7:0]        oRegData,
    output logic [ADDR_W-1:0] oAddr,
    output logic [3:0]        oRA,
    output logic [DOT_W-1:0]  oDA,
    output logic              oHs,
    output logic              oVs,
    output logic              oBlank,
    output logic              oCursor,
    output logic              oVRetrace
);

    localparam int unsigned X_W   = $clog2(H_TOT);
    localparam int unsigned Y_W   = $clog2(V_TOT);
    localparam int unsigned REP_W = (ROW_REP > 1) ? $clog2(ROW_REP) : 1;

    logic [X_W-1:0]         x;
    logic [Y_W-1:0]         y;
    logic [REP_W-1:0]       rep;
    logic [CRTC_SCAN_W-1:0] scan;
    logic [ADDR_W-1:0]      rowAddr;

    logic [ADDR_W-1:0]      shCur;
    logic [CRTC_SCAN_W-1:0] shMaxScan;
    logic [CRTC_SCAN_W-1:0] shCurStart;
    logic [CRTC_SCAN_W-1:0] shCurEnd;
    logic [CRTC_DATA_W-1:0] shStride;
    logic [ADDR_W-1:0]      startLoad;

    logic lineEnd;
    logic frameEnd;
    logic repEnd;
    logic blinkOn;

    assign lineEnd  = (x == X_W'(H_TOT - 1));
    assign frameEnd = lineEnd && (y == Y_W'(V_TOT - 1));
    assign repEnd   = (rep == REP_W'(ROW_REP - 1));

    crtc_regfile #(.ADDR_W(ADDR_W)) uRegs (
        .iClk25       (iClk25),
        .iRstN        (iRstN),
        .iRegIdx      (iRegIdx),
        .iRegWr       (iRegWr),
        .iRegData     (iRegData),
        .iFrameEnd    (frameEnd),
        .oRegData     (oRegData),
        .oCur         (shCur),
        .oMaxScan     (shMaxScan),
        .oCurStart    (shCurStart),
        .oCurEnd      (shCurEnd),
        .oStride      (shStride),
        .oStartLoad_c (startLoad)
    );

    // Raster position plus glyph-row tracking; row address steps by STRIDE per text row.
    always_ff @(posedge iClk25 or negedge iRstN) begin
        if (!iRstN) begin
            x       <= '0;
            y       <= '0;
            rep     <= '0;
            scan    <= '0;
            rowAddr <= '0;
        end else if (frameEnd) begin
            x       <= '0;
            y       <= '0;
            rep     <= '0;
            scan    <= '0;
            rowAddr <= startLoad;
        end else if (lineEnd) begin
            x <= '0;
            y <= y + Y_W'(1);
            if (repEnd) begin
                rep <= '0;
                if (scan == shMaxScan) begin
                    scan    <= '0;
                    rowAddr <= rowAddr + ADDR_W'(shStride);
                end else begin
                    scan <= scan + CRTC_SCAN_W'(1);
                end
            end else begin
                rep <= rep + REP_W'(1);
            end
        end else begin
            x <= x + X_W'(1);
        end
    end

`ifdef CRTC_CURSOR_BLINK_EN
    logic [4:0] frameCnt;

    always_ff @(posedge iClk25 or negedge iRstN) begin
        if (!iRstN) begin
            frameCnt <= '0;
        end else if (frameEnd) begin
            frameCnt <= frameCnt + 5'd1;
        end
    end

    assign blinkOn = ~frameCnt[4];
`else
    assign blinkOn = 1'b1;
`endif

    logic [ADDR_W-1:0] addrNext;
    logic              blankNext;
    logic              hsActive;
    logic              vsActive;
    logic              cursorNext;

    assign addrNext   = rowAddr + ADDR_W'(x[X_W-1:DOT_W]);
    assign blankNext  = (x >= X_W'(H_VIS)) || (y >= Y_W'(V_VIS));
    assign hsActive   = (x >= X_W'(H_VIS + H_FP)) && (x <= X_W'(H_VIS + H_FP + H_SYNC - 1));
    assign vsActive   = (y >= Y_W'(V_VIS + V_FP)) && (y <= Y_W'(V_VIS + V_FP + V_SYNC - 1));
    assign cursorNext = !blankNext && (addrNext == shCur) && (shCurStart <= scan)
                        && (scan <= shCurEnd) && blinkOn;

    // All outputs register the same counter state, so they stay mutually aligned.
    always_ff @(posedge iClk25 or negedge iRstN) begin
        if (!iRstN) begin
            oAddr     <= '0;
            oRA       <= '0;
            oDA       <= '0;
            oHs       <= ~HS_POL;
            oVs       <= ~VS_POL;
            oBlank    <= 1'b1;
            oCursor   <= 1'b0;
            oVRetrace <= 1'b0;
        end else begin
            oAddr     <= addrNext;
            oRA       <= scan;
            oDA       <= x[DOT_W-1:0];
            oHs       <= hsActive ? HS_POL : ~HS_POL;
            oVs       <= vsActive ? VS_POL : ~VS_POL;
            oBlank    <= blankNext;
            oCursor   <= cursorNext;
            oVRetrace <= (y >= Y_W'(V_VIS));
        end
    end

endmodule

// File: tb/tb_video_crtc_prog.sv
// Scoreboard bench for video_crtc_prog on a shortened raster (160x47 totals)
// so several frames fit in a short run; expectations derive from these parameters.
module tb_video_crtc_prog;

    localparam int unsigned H_VIS  = 128;
    localparam int unsigned H_FP   = 8;
    localparam int unsigned H_SYNC = 16;
    localparam int unsigned H_TOT  = 160;
    localparam int unsigned V_VIS  = 40;
    localparam int unsigned V_FP   = 3;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_TOT  = 47;
    localparam int unsigned FRAME  = H_TOT * V_TOT;
    localparam int unsigned RST_KEY = 32'hFFFF_FFFF;

    logic        iClk25 = 1'b0;
    logic        iRstN;
    logic [3:0]  iRegIdx;
    logic        iRegWr;
    logic [7:0]  iRegData;
    logic [7:0]  oRegData;
    logic [13:0] oAddr;
    logic [3:0]  oRA;
    logic [3:0]  oDA;
    logic        oHs;
    logic        oVs;
    logic        oBlank;
    logic        oCursor;
    logic        oVRetrace;

    video_crtc_prog #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_TOT(H_TOT),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_TOT(V_TOT),
        .HS_POL(1'b0), .VS_POL(1'b1), .ROW_REP(2), .DOT_W(4), .ADDR_W(14)
    ) dut (
        .iClk25    (iClk25),
        .iRstN     (iRstN),
        .iRegIdx   (iRegIdx),
        .iRegWr    (iRegWr),
        .iRegData  (iRegData),
        .oRegData  (oRegData),
        .oAddr     (oAddr),
        .oRA       (oRA),
        .oDA       (oDA),
        .oHs       (oHs),
        .oVs       (oVs),
        .oBlank    (oBlank),
        .oCursor   (oCursor),
        .oVRetrace (oVRetrace)
    );

    always #5 iClk25 = ~iClk25;

    typedef enum int {F_ADDR, F_RA, F_DA, F_HS, F_VS, F_BLANK, F_CUR, F_VR, F_RD} fld_t;
    typedef struct {
        int unsigned s;
        fld_t        fld;
        int unsigned val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned tick;
    int          nChecks = 0;
    int          nPass   = 0;

    // Edges since reset release; outputs seen after edge n describe counter state n-1.
    always @(posedge iClk25 or negedge iRstN) begin
        if (!iRstN) tick <= 0;
        else        tick <= tick + 1;
    end

    function automatic int unsigned stateIdx(input int unsigned f, input int unsigned y,
                                             input int unsigned x);
        return f * FRAME + y * H_TOT + x;
    endfunction

    task automatic push(input int unsigned s, input fld_t fld, input int unsigned val,
                        input string name);
        exp_t e;
        int   i;
        e.s = s; e.fld = fld; e.val = val; e.name = name;
        i = 0;
        while (i < sb.size() && sb[i].s <= s) i++;
        sb.insert(i, e);
    endtask

    task automatic ex(input int unsigned f, input int unsigned y, input int unsigned x,
                      input fld_t fld, input int unsigned val, input string name);
        push(stateIdx(f, y, x), fld, val, name);
    endtask

    task automatic pushRst(input string tag);
        push(RST_KEY, F_ADDR,  0, {tag, "_addr"});
        push(RST_KEY, F_RA,    0, {tag, "_ra"});
        push(RST_KEY, F_DA,    0, {tag, "_da"});
        push(RST_KEY, F_HS,    1, {tag, "_hs"});
        push(RST_KEY, F_VS,    0, {tag, "_vs"});
        push(RST_KEY, F_BLANK, 1, {tag, "_blank"});
        push(RST_KEY, F_CUR,   0, {tag, "_cursor"});
        push(RST_KEY, F_VR,    0, {tag, "_vretrace"});
        push(RST_KEY, F_RD,    0, {tag, "_regdata"});
    endtask

    function automatic int unsigned actual(input fld_t f);
        case (f)
            F_ADDR:  return 32'(oAddr);
            F_RA:    return 32'(oRA);
            F_DA:    return 32'(oDA);
            F_HS:    return 32'(oHs);
            F_VS:    return 32'(oVs);
            F_BLANK: return 32'(oBlank);
            F_CUR:   return 32'(oCursor);
            F_VR:    return 32'(oVRetrace);
            default: return 32'(oRegData);
        endcase
    endfunction

    task automatic check(input exp_t e);
        int unsigned a;
        a = actual(e.fld);
        nChecks++;
        if (a == e.val) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (state %0d)", e.name, a, e.val, e.s);
    endtask

    // Monitor: compare every expectation whose state the DUT is presenting now.
    always @(negedge iClk25) begin
        if (!iRstN) begin
            while (sb.size() > 0 && sb[0].s == RST_KEY) check(sb.pop_front());
        end else if (tick >= 1) begin
            while (sb.size() > 0 && sb[0].s != RST_KEY && sb[0].s <= tick - 1) begin
                exp_t e;
                e = sb.pop_front();
                if (e.s < tick - 1) begin
                    nChecks++;
                    $display("FAIL %s: state %0d skipped, now at %0d", e.name, e.s, tick - 1);
                end else begin
                    check(e);
                end
            end
        end
    end

    task automatic goto(input int unsigned t);
        while (tick < t) begin
            @(posedge iClk25);
            #1;
        end
    endtask

    task automatic wr(input int unsigned t, input logic [3:0] idx, input logic [7:0] d);
        goto(t);
        iRegWr = 1'b1; iRegIdx = idx; iRegData = d;
        @(posedge iClk25);
        #1;
        iRegWr = 1'b0;
    endtask

    task automatic rd(input int unsigned t, input logic [3:0] idx, input int unsigned v,
                      input string name);
        goto(t);
        iRegIdx = idx;
        push(t, F_RD, v, name);
    endtask

    task automatic plan();
        ex(0, 0, 0,   F_ADDR, 0, "f0_addr_origin");   ex(0, 0, 0, F_BLANK, 0, "f0_blank_origin");
        ex(0, 0, 17,  F_ADDR, 1, "f0_addr_x17");      ex(0, 0, 17, F_DA, 1, "f0_da_x17");
        ex(0, 0, 127, F_BLANK, 0, "hblank_x127");     ex(0, 0, 128, F_BLANK, 1, "hblank_x128");
        ex(0, 0, 135, F_HS, 1, "hs_x135");            ex(0, 0, 136, F_HS, 0, "hs_x136");
        ex(0, 0, 151, F_HS, 0, "hs_x151");            ex(0, 0, 152, F_HS, 1, "hs_x152");
        ex(0, 15, 127, F_ADDR, 7, "addr_y15_x127");   ex(0, 15, 127, F_RA, 7, "ra_y15");
        ex(0, 15, 127, F_DA, 15, "da_x127");
        ex(0, 16, 0, F_ADDR, 80, "addr_y16_x0");      ex(0, 16, 0, F_RA, 0, "ra_y16");
        ex(0, 32, 0, F_ADDR, 160, "f0_unchanged_after_start_wr");
        ex(0, 39, 0, F_BLANK, 0, "vblank_y39");       ex(0, 39, 0, F_VR, 0, "vr_y39");
        ex(0, 40, 0, F_BLANK, 1, "vblank_y40");       ex(0, 40, 0, F_VR, 1, "vr_y40");
        ex(0, 42, 0, F_VS, 0, "vs_y42");              ex(0, 43, 0, F_VS, 1, "vs_y43");
        ex(0, 44, 159, F_VS, 1, "vs_y44");            ex(0, 45, 0, F_VS, 0, "vs_y45");
        ex(0, 46, 159, F_BLANK, 1, "last_state_blank");
        ex(1, 0, 0, F_BLANK, 0, "frame_len_blank");   ex(1, 0, 0, F_VR, 0, "frame_len_vr");
        ex(1, 0, 0, F_ADDR, 32'h100, "f1_start_0100");
        ex(1, 16, 0, F_ADDR, 32'h150, "f1_row1");
        ex(2, 0, 0, F_ADDR, 32'h120, "boundary_write_start");
        ex(2, 0, 16, F_ADDR, 32'h121, "f2_x16");
        ex(2, 8, 0, F_ADDR, 32'h120, "f2_shadow_holds");
        ex(3, 0, 48, F_ADDR, 32'h3FFF, "wrap_pre");
        ex(3, 0, 64, F_ADDR, 32'h0000, "wrap_zero");
        ex(3, 0, 80, F_ADDR, 32'h0001, "wrap_post");
        ex(4, 12, 80, F_CUR, 1, "cur_y12_x80");       ex(4, 12, 95, F_CUR, 1, "cur_y12_x95");
        ex(4, 15, 80, F_CUR, 1, "cur_y15_x80");       ex(4, 15, 95, F_CUR, 1, "cur_y15_x95");
        ex(4, 12, 79, F_CUR, 0, "cur_x79");           ex(4, 12, 96, F_CUR, 0, "cur_x96");
        ex(4, 11, 80, F_CUR, 0, "cur_y11");           ex(4, 16, 80, F_CUR, 0, "cur_y16");
        ex(4, 14, 88, F_ADDR, 5, "cur_cell_addr");    ex(4, 14, 88, F_RA, 7, "cur_cell_ra");
        ex(5, 12, 80, F_CUR, 0, "cur_off_y12");       ex(5, 14, 85, F_CUR, 0, "cur_off_y14");
        ex(5, 14, 85, F_ADDR, 5, "cur_off_addr");
        ex(5, 31, 0, F_RA, 7, "f5_maxscan_unchanged"); ex(5, 32, 0, F_ADDR, 160, "f5_row2");
        ex(5, 32, 0, F_RA, 0, "f5_row2_ra");
        ex(6, 0, 0, F_RA, 0, "f6_ra0");               ex(6, 7, 0, F_RA, 3, "f6_maxscan3");
        ex(6, 8, 0, F_ADDR, 80, "f6_row1_addr");      ex(6, 8, 0, F_RA, 0, "f6_row1_ra");
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: run did not complete, %0d expectations pending", sb.size());
        $fatal(1);
    end

    initial begin
        iRstN = 1'b0; iRegWr = 1'b0; iRegIdx = 4'd0; iRegData = 8'd0;
        pushRst("rst");
        @(negedge iClk25);
        #1;
        plan();
        iRegIdx = 4'd7;
        push(0, F_RD, 80, "rd_stride_rst");
        #20 iRstN = 1'b1;

        rd(1, 4'd4, 7, "rd_maxscan_rst");
        rd(2, 4'd5, 6, "rd_curstart_rst");
        rd(3, 4'd6, 7, "rd_curend_rst");
        wr(4, 4'd9, 8'hFF);
        push(4, F_RD, 0, "rd_idx9");
        rd(5, 4'd0, 0, "rd_starthi_rst");

        wr(stateIdx(0, 30, 5), 4'd0, 8'h01);
        wr(stateIdx(1, 46, 159), 4'd1, 8'h20);
        wr(stateIdx(2, 5, 0), 4'd0, 8'hFF);
        wr(stateIdx(2, 5, 1), 4'd1, 8'hFC);
        rd(stateIdx(2, 6, 0), 4'd0, 32'h3F, "rd_starthi_masked");
        rd(stateIdx(2, 6, 1), 4'd1, 32'hFC, "rd_startlo");
        wr(stateIdx(3, 5, 0), 4'd0, 8'h00);
        wr(stateIdx(3, 5, 1), 4'd1, 8'h00);
        wr(stateIdx(3, 5, 2), 4'd2, 8'h00);
        wr(stateIdx(3, 5, 3), 4'd3, 8'h05);
        wr(stateIdx(4, 20, 0), 4'd5, 8'h07);
        wr(stateIdx(4, 20, 1), 4'd6, 8'h06);
        rd(stateIdx(4, 21, 0), 4'd5, 7, "rd_curstart");
        rd(stateIdx(4, 21, 1), 4'd6, 6, "rd_curend");
        wr(stateIdx(5, 20, 0), 4'd4, 8'h03);
        rd(stateIdx(5, 21, 0), 4'd4, 3, "rd_maxscan");

        // Mid-line asynchronous reset, asserted in the high phase of the clock.
        goto(stateIdx(6, 10, 100));
        pushRst("midrst");
        #2 iRstN = 1'b0;
        @(negedge iClk25);
        #1;
        iRegIdx = 4'd7;
        push(0, F_RD, 80, "rd_stride_after_rst");
        ex(0, 0, 0, F_ADDR, 0, "rst_addr_origin");
        ex(0, 0, 0, F_BLANK, 0, "rst_blank_origin");
        ex(0, 0, 0, F_HS, 1, "rst_hs_origin");
        ex(0, 0, 3, F_DA, 3, "rst_da_x3");
        ex(0, 16, 0, F_ADDR, 80, "rst_addr_y16");
        ex(0, 20, 0, F_RA, 2, "rst_ra_y20");
        @(posedge iClk25);
        #2 iRstN = 1'b1;
        goto(stateIdx(0, 20, 0) + 3);

        if (sb.size() != 0) begin
            nChecks += sb.size();
            $display("FAIL pending: %0d expectations never reached", sb.size());
        end
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
